uart_receiver: RTL and testbench

UART receive channel of the SoC peripheral set, and the receive-side counterpart of the SoC's `uart_tx` transmitter. It deserialises 8-bit frames arriving on `uart_rx` (1 start bit, 8 data bits LSB-first, optional parity, 1 stop bit) and buffers them in a small FIFO. The FIFO is drained by the CPU bus-side logic through a valid/ready handshake. Errors are reported as framing pulses, parity pulses and a sticky overrun flag.

---
 rtl/uart_receiver.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_receiver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8-bit UART receive channel with a small first-word
// fall-through FIFO drained through a valid/ready handshake.
//
// Frame: 1 start bit, 8 data bits LSB-first, optional even parity, 1 stop bit.
// Optional feature macro: UART_RX_PARITY_EN (adds the parity bit and makes
// parity_err live; without it the frame is 10 bits and parity_err is 0).
//
// Parameters:
//   CLK_FREQ    sys_clk frequency in Hz
//   BAUD        line rate; CLKS_PER_BIT = CLK_FREQ / BAUD
//   FIFO_DEPTH  receive FIFO entries, power of two, >= 2
// Ports:
//   sys_clk      system clock
//   sys_reset    asynchronous active-low reset
//   uart_rx      serial input, asynchronous, idle high
//   rx_data      FIFO head byte (first-word fall-through)
//   rx_valid     FIFO not empty
//   rx_ready     consumer pops the head byte when rx_valid & rx_ready
//   fifo_count   bytes currently held
//   frame_err    one-cycle pulse: stop bit sampled low
//   parity_err   one-cycle pulse: parity mismatch
//   overrun      sticky: good byte dropped because the FIFO was full
//   overrun_clr  clears overrun (a coincident new overrun wins)

module uart_receiver #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_reset,
    input  logic                          uart_rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    input  logic                          overrun_clr
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W       = PTR_W + 1;

    localparam logic [CNT_W-1:0]  HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // Two-flop synchroniser, idles high
    logic [1:0] sync_q;
    logic       rxs;

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) sync_q <= 2'b11;
        else            sync_q <= {sync_q[0], uart_rx};
    end

    assign rxs = sync_q[1];

    // Receive state machine
    state_t           state, state_next;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift, shift_next;
    logic             armed, armed_next;
    logic             tick_c;
    logic             push_c;
    logic             frame_err_next;
    logic             parity_err_next;
`ifdef UART_RX_PARITY_EN
    logic             par_bad, par_bad_next;
`endif

    assign tick_c = (bit_cnt == '0);

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            armed      <= 1'b1;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            bit_idx    <= bit_idx_next;
            shift      <= shift_next;
            armed      <= armed_next;
            frame_err  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
            par_bad    <= par_bad_next;
            parity_err <= parity_err_next;
`endif
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_next      = state;
        bit_cnt_next    = bit_cnt;
        bit_idx_next    = bit_idx;
        shift_next      = shift;
        armed_next      = armed;
        push_c          = 1'b0;
        frame_err_next  = 1'b0;
        parity_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next    = par_bad;
`endif

        case (state)
            S_IDLE: begin
                // After a framing error the line must return high before re-arming
                if (!armed) begin
                    if (rxs) armed_next = 1'b1;
                end else if (!rxs) begin
                    state_next   = S_START;
                    bit_cnt_next = HALF_LOAD;
                end
            end

            S_START: begin
                if (!tick_c) begin
                    bit_cnt_next = bit_cnt - CNT_W'(1);
                end else if (rxs) begin
                    state_next = S_IDLE;
                end else begin
                    state_next   = S_DATA;
                    bit_cnt_next = FULL_LOAD;
                    bit_idx_next = 3'd0;
`ifdef UART_RX_PARITY_EN
                    par_bad_next = 1'b0;
`endif
                end
            end

            S_DATA: begin
                if (!tick_c) begin
                    bit_cnt_next = bit_cnt - CNT_W'(1);
                end else begin
                    shift_next   = {rxs, shift[7:1]};
                    bit_cnt_next = FULL_LOAD;
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (!tick_c) begin
                    bit_cnt_next = bit_cnt - CNT_W'(1);
                end else begin
                    par_bad_next = (rxs != ^shift);
                    bit_cnt_next = FULL_LOAD;
                    state_next   = S_STOP;
                end
            end
`endif

            S_STOP: begin
                if (!tick_c) begin
                    bit_cnt_next = bit_cnt - CNT_W'(1);
                end else begin
                    state_next = S_IDLE;
                    if (!rxs) begin
                        frame_err_next = 1'b1;
                        armed_next     = 1'b0;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad) begin
                        parity_err_next = 1'b1;
`endif
                    end else begin
                        push_c = 1'b1;
                    end
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

    // Receive FIFO
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             pop_c, full_c, wr_c, ovr_set_c;
    logic [FCNT_W-1:0] count_next;

    assign pop_c     = rx_ready & rx_valid;
    assign full_c    = (fifo_count == FIFO_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign wr_c      = push_c & (~full_c | pop_c);
    assign ovr_set_c = push_c & full_c & ~pop_c;

    always_comb begin
        count_next = fifo_count;
        if (wr_c && !pop_c)      count_next = fifo_count + FCNT_W'(1);
        else if (!wr_c && pop_c) count_next = fifo_count - FCNT_W'(1);
    end

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rx_valid   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (wr_c) begin
                mem[wr_ptr] <= shift_next;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= count_next;
            rx_valid   <= (count_next != '0);
            // Set has priority over clear
            if (ovr_set_c)        overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
        end
    end

    assign rx_data = mem[rd_ptr];

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver at default parameters (434 clocks/bit).
module tb_uart_receiver;

    localparam int CPB        = 434;
    localparam int START_EDGE = 3 + CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int PUSH_EDGE  = START_EDGE + (FRAME_BITS - 1) * CPB;

    logic       sys_clk = 1'b0;
    logic       sys_reset;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       overrun_clr;

    int n_cmp  = 0;
    int n_fail = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;
    int fe0, pe0;

    uart_receiver dut (
        .sys_clk     (sys_clk),
        .sys_reset   (sys_reset),
        .uart_rx     (uart_rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .fifo_count  (fifo_count),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #10 sys_clk = ~sys_clk;

    // Count high cycles of the error pulses
    always @(negedge sys_clk) begin
        if (frame_err === 1'b1)  fe_cnt <= fe_cnt + 1;
        if (parity_err === 1'b1) pe_cnt <= pe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame starting at the current time; stop = 0 forces a framing error
    task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (CPB) @(negedge sys_clk);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = par_ok ? ^d : ~(^d);
        repeat (CPB) @(negedge sys_clk);
`else
        if (par_ok) uart_rx = 1'b1;
`endif
        uart_rx = stop;
        repeat (CPB) @(negedge sys_clk);
    endtask

    task automatic pop();
        @(negedge sys_clk);
        rx_ready = 1'b1;
        @(negedge sys_clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        sys_reset   = 1'b0;
        uart_rx     = 1'b1;
        rx_ready    = 1'b0;
        overrun_clr = 1'b0;
        repeat (5) @(negedge sys_clk);

        check("rst_valid",   32'(rx_valid),   32'd0);
        check("rst_data",    32'(rx_data),    32'd0);
        check("rst_count",   32'(fifo_count), 32'd0);
        check("rst_fe",      32'(frame_err),  32'd0);
        check("rst_pe",      32'(parity_err), 32'd0);
        check("rst_overrun", 32'(overrun),    32'd0);

        sys_reset = 1'b1;
        repeat (5) @(negedge sys_clk);

        // Good byte
        fe0 = fe_cnt; pe0 = pe_cnt;
        send_frame(8'hA5, 1'b1, 1'b1);
        check("a5_valid", 32'(rx_valid),   32'd1);
        check("a5_data",  32'(rx_data),    32'hA5);
        check("a5_count", 32'(fifo_count), 32'd1);
        pop();
        check("a5_pop_valid", 32'(rx_valid),   32'd0);
        check("a5_pop_count", 32'(fifo_count), 32'd0);

        // Glitch shorter than half a bit is a false start
        uart_rx = 1'b0;
        repeat (100) @(negedge sys_clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge sys_clk);
        check("glitch_count", 32'(fifo_count), 32'd0);
        check("glitch_fe",    32'(fe_cnt - fe0), 32'd0);
        check("glitch_pe",    32'(pe_cnt - pe0), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b1);
        check("3c_data",  32'(rx_data),    32'h3C);
        check("3c_count", 32'(fifo_count), 32'd1);
        pop();

        // Framing error followed by a long break
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b1, 1'b0);
        repeat (20 * CPB) @(negedge sys_clk);
        check("fe_pulse", 32'(fe_cnt - fe0), 32'd1);
        check("fe_count", 32'(fifo_count),   32'd0);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge sys_clk);
        send_frame(8'h12, 1'b1, 1'b1);
        check("12_data",  32'(rx_data),    32'h12);
        check("12_count", 32'(fifo_count), 32'd1);
        check("12_fe",    32'(fe_cnt - fe0), 32'd1);
        pop();

`ifdef UART_RX_PARITY_EN
        // Parity: wrong bit discards, correct bit receives
        pe0 = pe_cnt;
        send_frame(8'h07, 1'b0, 1'b1);
        check("par_pulse", 32'(pe_cnt - pe0), 32'd1);
        check("par_count", 32'(fifo_count),   32'd0);
        send_frame(8'h07, 1'b1, 1'b1);
        check("par_ok_data", 32'(rx_data),       32'h07);
        check("par_ok_pe",   32'(pe_cnt - pe0),  32'd1);
        pop();
`endif

        // Overrun: fifth byte dropped
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b1);
        check("ovr_count", 32'(fifo_count), 32'd4);
        check("ovr_flag",  32'(overrun),    32'd1);
        check("ovr_head",  32'(rx_data),    32'h01);
        @(negedge sys_clk);
        overrun_clr = 1'b1;
        @(negedge sys_clk);
        overrun_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);

        // Full FIFO: pop exactly in the push cycle of the next byte
        fork
            send_frame(8'h06, 1'b1, 1'b1);
            begin
                repeat (PUSH_EDGE - 1) @(posedge sys_clk);
                @(negedge sys_clk);
                rx_ready = 1'b1;
                @(negedge sys_clk);
                rx_ready = 1'b0;
            end
        join
        check("pp_overrun", 32'(overrun),    32'd0);
        check("pp_count",   32'(fifo_count), 32'd4);
        check("pp_head02",  32'(rx_data),    32'h02);
        pop();
        check("pp_head03",  32'(rx_data),    32'h03);
        pop();
        check("pp_head04",  32'(rx_data),    32'h04);
        pop();
        check("pp_last06",  32'(rx_data),    32'h06);
        check("pp_count1",  32'(fifo_count), 32'd1);

        // Reset in the middle of data bit 4, FIFO holding one byte
        fe0 = fe_cnt; pe0 = pe_cnt;
        check("pre_rst_valid", 32'(rx_valid), 32'd1);
        fork
            send_frame(8'h5A, 1'b1, 1'b1);
            begin
                repeat (START_EDGE + 4 * CPB + 100) @(posedge sys_clk);
                #1 sys_reset = 1'b0;
                #1;
                check("mid_rst_valid", 32'(rx_valid),   32'd0);
                check("mid_rst_data",  32'(rx_data),    32'd0);
                check("mid_rst_count", 32'(fifo_count), 32'd0);
                check("mid_rst_ovr",   32'(overrun),    32'd0);
            end
        join
        @(negedge sys_clk);
        sys_reset = 1'b1;
        repeat (2 * CPB) @(negedge sys_clk);
        check("post_rst_count", 32'(fifo_count),   32'd0);
        check("post_rst_valid", 32'(rx_valid),     32'd0);
        check("post_rst_fe",    32'(fe_cnt - fe0), 32'd0);
        check("post_rst_pe",    32'(pe_cnt - pe0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
